// File: rtl/updown_top_game.sv
// ---------------------------------------------------------------------------
// updown_top_game
//
// Top level of the up/down number-guessing game. A free-running 7-bit LFSR
// supplies the secret target, which is latched on the first guess of a round.
// Every later guess is compared against that frozen target. A 7-segment hint
// shows "U" (go up), "d" (go down), "O" (correct) or "-" (out of tries).
//
// Parameters
//   MAX_TRIES  wrong guesses allowed per round before LOSE (1..15)
//   LFSR_SEED  non-zero LFSR value loaded on reset
//
// Ports
//   clk                in   system clock, rising edge
//   reset              in   synchronous, active-high reset
//   guess_trigger      in   guess strobe; only its rising edge is used
//   user_input[6:0]    in   player guess, unsigned 0..127
//   seg_display[6:0]   out  segments {g,f,e,d,c,b,a}, active-high, registered
//   random_number_out  out  target register (debug reveal)
//
// Configuration
//   GAME_REVEAL_EN  defined:   random_number_out shows the target register
//                   undefined: random_number_out is tied to 7'd0
// ---------------------------------------------------------------------------
module updown_top_game #(
    parameter int         MAX_TRIES = 7,
    parameter logic [6:0] LFSR_SEED = 7'h01
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       guess_trigger,
    input  logic [6:0] user_input,
    output logic [6:0] seg_display,
    output logic [6:0] random_number_out
);

    typedef enum logic [1:0] {
        ST_START,
        ST_PLAY,
        ST_WIN,
        ST_LOSE
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_UP    = 7'b0111110;  // "U"
    localparam logic [6:0] SEG_DOWN  = 7'b1011110;  // "d"
    localparam logic [6:0] SEG_OK    = 7'b0111111;  // "O"
    localparam logic [6:0] SEG_DASH  = 7'b1000000;  // "-"

    localparam logic [3:0] MAX_TRIES_L = 4'(MAX_TRIES);

    state_t     r_state;
    logic [6:0] r_lfsr;
    logic [6:0] r_target;
    logic [3:0] r_tries;
    logic       r_trig_d;
    logic [6:0] r_seg;

    logic       w_edge;
    logic [6:0] w_lfsr_next;
    logic [6:0] w_cmp_target;
    logic [3:0] w_cmp_tries;
    logic       w_eval;

    // Taps 6 and 5 give a maximal-length (127) sequence that never reaches 0.
    assign w_lfsr_next = {r_lfsr[5:0], r_lfsr[6] ^ r_lfsr[5]};

    // A strobe held high counts once.
    assign w_edge = guess_trigger & ~r_trig_d;

    // The first guess of a round is judged against the LFSR value being
    // latched this very cycle, and it is guess number 1; later guesses use
    // the frozen target and the running try count.
    assign w_cmp_target = (r_state == ST_START) ? r_lfsr : r_target;
    assign w_cmp_tries  = (r_state == ST_START) ? 4'd1 : r_tries;
    assign w_eval       = w_edge && (r_state == ST_START || r_state == ST_PLAY);

    // NOTE: all state lives in this one block and uses non-blocking
    // assignments, so every right-hand side sees pre-edge values and the
    // evaluation order of the statements below does not matter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_START;
            r_lfsr   <= LFSR_SEED;
            r_target <= 7'd0;
            r_tries  <= 4'd0;
            r_trig_d <= 1'b0;
            r_seg    <= SEG_BLANK;
        end else begin
            r_lfsr   <= w_lfsr_next;
            r_trig_d <= guess_trigger;

            if (w_eval) begin
                if (r_state == ST_START) begin
                    r_target <= r_lfsr;
                end
                if (user_input == w_cmp_target) begin
                    r_seg   <= SEG_OK;
                    r_state <= ST_WIN;
                    r_tries <= w_cmp_tries;
                end else if (w_cmp_tries == MAX_TRIES_L) begin
                    r_seg   <= SEG_DASH;
                    r_state <= ST_LOSE;
                    r_tries <= w_cmp_tries;
                end else begin
                    r_seg   <= (user_input < w_cmp_target) ? SEG_UP : SEG_DOWN;
                    r_state <= ST_PLAY;
                    r_tries <= w_cmp_tries + 4'd1;
                end
            end else if (w_edge && (r_state == ST_WIN || r_state == ST_LOSE)) begin
                // Acknowledge strobe: start a new round, guess not evaluated.
                r_seg   <= SEG_BLANK;
                r_state <= ST_START;
            end
        end
    end

    assign seg_display = r_seg;

`ifdef GAME_REVEAL_EN
    assign random_number_out = r_target;
`else
    assign random_number_out = 7'd0;
`endif

endmodule

// File: tb/tb_updown_top_game.sv
// ---------------------------------------------------------------------------
// tb_updown_top_game
//
// Self-checking bench for updown_top_game. A behavioural reference model is
// advanced once per clock with the same inputs as the DUT; its expected
// outputs go into a scoreboard queue and are compared against the DUT one
// time unit after the clock edge. Scenario tasks add explicit checks of the
// literal hint patterns at the key points of each scenario.
// ---------------------------------------------------------------------------
module tb_updown_top_game;

    localparam int MAX_TRIES = 7;

`ifdef GAME_REVEAL_EN
    localparam bit REVEAL = 1'b1;
`else
    localparam bit REVEAL = 1'b0;
`endif

    localparam logic [6:0] P_BLANK = 7'b0000000;
    localparam logic [6:0] P_UP    = 7'b0111110;
    localparam logic [6:0] P_DOWN  = 7'b1011110;
    localparam logic [6:0] P_OK    = 7'b0111111;
    localparam logic [6:0] P_DASH  = 7'b1000000;

    logic       clk;
    logic       reset;
    logic       guess_trigger;
    logic [6:0] user_input;
    logic [6:0] seg_display;
    logic [6:0] random_number_out;

    int total;
    int bad;

    updown_top_game #(
        .MAX_TRIES(MAX_TRIES),
        .LFSR_SEED(7'h01)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .guess_trigger    (guess_trigger),
        .user_input       (user_input),
        .seg_display      (seg_display),
        .random_number_out(random_number_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef enum int { M_START, M_PLAY, M_WIN, M_LOSE } m_state_t;

    m_state_t   m_state;
    logic [6:0] m_lfsr;
    logic [6:0] m_target;
    int         m_tries;
    logic       m_trig;
    logic [6:0] m_seg;

    typedef struct {
        string      tag;
        logic [6:0] seg;
        logic [6:0] rno;
    } exp_t;

    exp_t sb_q[$];

    // Advance the model by one clock using the currently driven inputs,
    // queue its outputs, clock the DUT and compare.
    task automatic step(input string tag);
        exp_t e;
        exp_t got;
        logic hit;
        if (reset) begin
            m_state  = M_START;
            m_lfsr   = 7'h01;
            m_target = 7'd0;
            m_tries  = 0;
            m_seg    = P_BLANK;
        end else begin
            hit = guess_trigger && !m_trig;
            if (hit) begin
                if (m_state == M_WIN || m_state == M_LOSE) begin
                    m_state = M_START;
                    m_seg   = P_BLANK;
                end else begin
                    if (m_state == M_START) begin
                        m_target = m_lfsr;
                        m_tries  = 1;
                    end
                    if (user_input == m_target) begin
                        m_seg   = P_OK;
                        m_state = M_WIN;
                    end else if (m_tries == MAX_TRIES) begin
                        m_seg   = P_DASH;
                        m_state = M_LOSE;
                    end else begin
                        m_seg   = (user_input < m_target) ? P_UP : P_DOWN;
                        m_tries = m_tries + 1;
                        m_state = M_PLAY;
                    end
                end
            end
            m_lfsr = {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[5]};
        end
        m_trig = reset ? 1'b0 : guess_trigger;

        e.tag = tag;
        e.seg = m_seg;
        e.rno = REVEAL ? m_target : 7'd0;
        sb_q.push_back(e);

        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        total++;
        if (seg_display !== got.seg) begin
            bad++;
            $display("FAIL %s seg_display got=%b want=%b", got.tag, seg_display, got.seg);
        end
        total++;
        if (random_number_out !== got.rno) begin
            bad++;
            $display("FAIL %s random_number_out got=%0d want=%0d", got.tag, random_number_out, got.rno);
        end
    endtask

    // One guess: strobe high for one cycle, then low for one cycle.
    task automatic guess(input string tag, input logic [6:0] val);
        guess_trigger = 1'b1;
        user_input    = val;
        step(tag);
        guess_trigger = 1'b0;
        step(tag);
    endtask

    task automatic do_reset(input int cycles);
        reset         = 1'b1;
        guess_trigger = 1'b0;
        for (int i = 0; i < cycles; i++) step("reset");
        reset = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        do_reset(10);
        total++;
        if (seg_display !== P_BLANK) begin
            bad++;
            $display("FAIL reset_seg got=%b want=%b", seg_display, P_BLANK);
        end
        total++;
        if (random_number_out !== 7'd0) begin
            bad++;
            $display("FAIL reset_rno got=%0d want=0", random_number_out);
        end
    endtask

    // Guess at the first edge after reset release hits the seed value 1.
    task automatic test_first_win;
        guess_trigger = 1'b1;
        user_input    = 7'd1;
        step("first_win");
        total++;
        if (seg_display !== P_OK) begin
            bad++;
            $display("FAIL first_win_seg got=%b want=%b", seg_display, P_OK);
        end
        total++;
        if (random_number_out !== (REVEAL ? 7'd1 : 7'd0)) begin
            bad++;
            $display("FAIL first_win_rno got=%0d want=%0d", random_number_out, REVEAL ? 1 : 0);
        end
        guess_trigger = 1'b0;
        // Display and revealed target hold in WIN while user_input wanders.
        for (int i = 0; i < 4; i++) begin
            user_input = 7'(i * 31);
            step("win_hold");
        end
        guess("win_ack", 7'd1);
        total++;
        if (seg_display !== P_BLANK) begin
            bad++;
            $display("FAIL win_ack_seg got=%b want=%b", seg_display, P_BLANK);
        end
    endtask

    // Target 2: guess high, low, then correct.
    task automatic test_up_down;
        do_reset(1);
        step("idle_after_reset");
        guess("g_high", 7'd100);
        total++;
        if (seg_display !== P_DOWN) begin
            bad++;
            $display("FAIL g_high_seg got=%b want=%b", seg_display, P_DOWN);
        end
        // Input changes without a strobe must be ignored.
        user_input = 7'd2;
        step("no_strobe");
        user_input = 7'd127;
        step("no_strobe");
        guess("g_low", 7'd0);
        total++;
        if (seg_display !== P_UP) begin
            bad++;
            $display("FAIL g_low_seg got=%b want=%b", seg_display, P_UP);
        end
        guess("g_hit", 7'd2);
        total++;
        if (seg_display !== P_OK) begin
            bad++;
            $display("FAIL g_hit_seg got=%b want=%b", seg_display, P_OK);
        end
        total++;
        if (random_number_out !== (REVEAL ? 7'd2 : 7'd0)) begin
            bad++;
            $display("FAIL g_hit_rno got=%0d want=%0d", random_number_out, REVEAL ? 2 : 0);
        end
    endtask

    // Seven wrong guesses against target 1, then the acknowledge strobe.
    task automatic test_lose;
        do_reset(1);
        for (int g = 1; g <= MAX_TRIES; g++) begin
            guess("lose_seq", 7'd127);
            total++;
            if (seg_display !== ((g == MAX_TRIES) ? P_DASH : P_DOWN)) begin
                bad++;
                $display("FAIL lose_guess%0d got=%b want=%b", g, seg_display,
                         (g == MAX_TRIES) ? P_DASH : P_DOWN);
            end
        end
        guess("lose_ack", 7'd1);
        total++;
        if (seg_display !== P_BLANK) begin
            bad++;
            $display("FAIL lose_ack_seg got=%b want=%b", seg_display, P_BLANK);
        end
    endtask

    // A strobe held for 5 cycles is one guess: LOSE still lands on guess 7.
    task automatic test_held_strobe;
        do_reset(1);
        guess("held_g1", 7'd127);
        guess_trigger = 1'b1;
        user_input    = 7'd127;
        for (int i = 0; i < 5; i++) step("held_high");
        guess_trigger = 1'b0;
        step("held_release");
        for (int g = 3; g <= MAX_TRIES; g++) begin
            guess("held_seq", 7'd0);
            total++;
            if (seg_display !== ((g == MAX_TRIES) ? P_DASH : P_UP)) begin
                bad++;
                $display("FAIL held_guess%0d got=%b want=%b", g, seg_display,
                         (g == MAX_TRIES) ? P_DASH : P_UP);
            end
        end
    endtask

    // Reset mid-round with a simultaneous strobe; reset wins and the LFSR
    // restarts from the seed, so the next first guess of 1 wins.
    task automatic test_reset_mid_play;
        do_reset(1);
        for (int g = 0; g < 3; g++) guess("mid_wrong", 7'd50);
        reset         = 1'b1;
        guess_trigger = 1'b1;
        user_input    = 7'd1;
        step("mid_reset");
        total++;
        if (seg_display !== P_BLANK) begin
            bad++;
            $display("FAIL mid_reset_seg got=%b want=%b", seg_display, P_BLANK);
        end
        reset = 1'b0;
        step("mid_regame");
        total++;
        if (seg_display !== P_OK) begin
            bad++;
            $display("FAIL mid_regame_seg got=%b want=%b", seg_display, P_OK);
        end
        guess_trigger = 1'b0;
        step("mid_idle");
    endtask

    // Random play against the model, including back-to-back strobes.
    task automatic test_back_to_back;
        do_reset(1);
        for (int i = 0; i < 200; i++) begin
            guess_trigger = 1'($urandom_range(0, 1));
            user_input    = 7'($urandom_range(0, 127));
            step("random");
        end
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        reset         = 1'b1;
        guess_trigger = 1'b0;
        user_input    = 7'd0;
        test_reset();
        test_first_win();
        test_up_down();
        test_lose();
        test_held_strobe();
        test_reset_mid_play();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/updown_top_game.md
# updown_top_game

Top level of the up/down number-guessing game. It does four things:
- Draws a secret 7-bit target from a free-running LFSR.
- Compares each player guess on `user_input` against the target.
- Drives a 7-segment hint ("U" = go up, "d" = go down, "O" = correct, "-" = out of tries).
- Optionally exposes the target for debug.

It sits directly under the board wrapper and takes switches and a single-cycle guess strobe from the input-conditioning logic.

## Interface
- `MAX_TRIES`, default 7: wrong guesses allowed per round before LOSE (range 1..15).
- `LFSR_SEED`, default 7'h01: LFSR value loaded on reset; must be non-zero.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  one clock; reset is synchronous and active-high.
- `guess_trigger`  in  1  synchronous guess strobe; a guess is taken on its rising edge.
- `user_input`  in  7  player guess, unsigned 0..127.
- `seg_display`  out  7  segment pattern {g,f,e,d,c,b,a}, active-high, registered.
- `random_number_out`  out  7  current target, registered.

## Operation
- LFSR:
  - 7-bit Fibonacci, next = {lfsr[5:0], lfsr[6]^lfsr[5]}, period 127, never 0.
  - Advances every non-reset cycle in every state.
- Edge detect: `trig_d` registers `guess_trigger`. `edge` = `guess_trigger & ~trig_d`. A level held high counts once.
- States: START, PLAY, WIN, LOSE.
- START:
  - Display blank, 7'b0000000.
  - On `edge`: target <= lfsr (current value), tries <= 1, go to PLAY.
  - The same guess is evaluated against that current lfsr value.
- PLAY:
  - On `edge`, unsigned compare of `user_input` with target.
  - Equal: display "O" 7'b0111111, go to WIN.
  - Guess < target: display "U" 7'b0111110.
  - Guess > target: display "d" 7'b1011110.
  - Wrong guess with tries == `MAX_TRIES`: display "-" 7'b1000000, go to LOSE. Otherwise tries <= tries+1.
- Guess-evaluation rules (START and PLAY):
  - The first guess in START is evaluated identically, including immediate WIN.
  - With `MAX_TRIES` = 1, a wrong first guess goes to LOSE.
- WIN / LOSE:
  - Display holds.
  - On `edge`: go to START and blank the display. This guess is not evaluated.
- Target is frozen from the START→PLAY transition until the next START.
- `user_input` is sampled only on the `edge` cycle. Changes at other times have no effect.

## Timing
- Reset values:
  - state = START, lfsr = `LFSR_SEED`, target = 0, tries = 0, `trig_d` = 0.
  - `seg_display` = 7'b0000000, `random_number_out` = 0.
- Latency: a guess sampled at edge N updates `seg_display` and state at edge N; visible after edge N (1 cycle from strobe assertion).
- Strobe rule: back-to-back guesses need `guess_trigger` low for ≥1 cycle between them.
- Reset mid-round aborts the round; all registers return to reset values at the next edge.
- Reset dominates a simultaneous `edge`.

## Configuration
- `GAME_REVEAL_EN` defined: `random_number_out` = target register.
  - Tracks lfsr only at the START→PLAY load.
  - Shows the frozen target in PLAY/WIN/LOSE.
- `GAME_REVEAL_EN` undefined: `random_number_out` tied to 7'd0. Game behaviour is otherwise identical.

## Test plan
- Reset held 10 cycles, released; `guess_trigger` high with `user_input`=1 at the first edge after release (lfsr=7'h01) → `seg_display`=7'b0111111, state WIN, `random_number_out`=1 (reveal on).
- Reset, first guess at the second edge after release (lfsr=7'h02) with `user_input`=100 → display 7'b1011110. Next guess 0 → 7'b0111110. Next guess 2 → 7'b0111111.
- Reset, 7 wrong guesses (`user_input`=127 against target 1) → display "d" on guesses 1..6, "-" 7'b1000000 on guess 7, state LOSE. 8th strobe → blank, START.
- `guess_trigger` held high 5 cycles in PLAY → exactly one guess counted (tries increments by 1).
- Reset asserted mid-PLAY after 3 wrong guesses → next cycle display 0, tries 0, lfsr 7'h01, START.
- `GAME_REVEAL_EN` undefined, run the first scenario → `random_number_out` stays 0 throughout; display still 7'b0111111.
